// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV64IM decode stage: major opcodes, the ALU
// operation encoding driven onto alu_control, the internal decoded-bundle
// struct and small immediate-formatting helpers.
// Immediates are built at the widest supported XLEN (64) and truncated by the
// consumer; sign-extend-then-truncate equals sign-extension at the narrow width.
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam int IMM_MAX_W = 64;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // ALU_NONE doubles as the "no legal decode" marker.
    typedef enum logic [5:0] {
        ALU_NONE   = 6'h00,
        ALU_ADDI   = 6'h01, ALU_SLTI   = 6'h02, ALU_SLTIU  = 6'h03,
        ALU_XORI   = 6'h04, ALU_ORI    = 6'h05, ALU_ANDI   = 6'h06,
        ALU_SLLI   = 6'h07, ALU_SRLI   = 6'h08, ALU_SRAI   = 6'h09,
        ALU_ADD    = 6'h0C, ALU_SUB    = 6'h0D, ALU_SLL    = 6'h0E,
        ALU_SLT    = 6'h0F, ALU_SLTU   = 6'h10, ALU_XOR    = 6'h11,
        ALU_SRL    = 6'h12, ALU_SRA    = 6'h13, ALU_OR     = 6'h14,
        ALU_AND    = 6'h15, ALU_ADDIW  = 6'h16, ALU_SLLIW  = 6'h17,
        ALU_SRLIW  = 6'h18, ALU_SRAIW  = 6'h19, ALU_ADDW   = 6'h1A,
        ALU_SUBW   = 6'h1B, ALU_SLLW   = 6'h1C, ALU_SRLW   = 6'h1D,
        ALU_SRAW   = 6'h1E, ALU_MUL    = 6'h1F, ALU_MULH   = 6'h20,
        ALU_MULHSU = 6'h21, ALU_MULHU  = 6'h22, ALU_DIV    = 6'h23,
        ALU_DIVU   = 6'h24, ALU_REM    = 6'h25, ALU_REMU   = 6'h26,
        ALU_MULW   = 6'h27, ALU_DIVW   = 6'h28, ALU_DIVUW  = 6'h29,
        ALU_REMW   = 6'h2A, ALU_REMUW  = 6'h2B, ALU_LUI    = 6'h2C,
        ALU_AUIPC  = 6'h2D
    } alu_op_e;

    typedef struct packed {
        alu_op_e                alu;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic [IMM_MAX_W-1:0]   imm;
        logic                   mux_b;
        logic                   rd_we;
        logic                   illegal;
        logic                   use_rs1;   // rs1 participates in RAW check
        logic                   use_rs2;   // rs2 participates in RAW check
    } decoded_t;

    // I-type immediate, sign-extended.
    function automatic logic [IMM_MAX_W-1:0] sext_i(input logic [11:0] f);
        return {{(IMM_MAX_W-12){f[11]}}, f};
    endfunction

    // U-type immediate {f, 12'b0}, sign-extended from bit 31.
    function automatic logic [IMM_MAX_W-1:0] sext_u(input logic [19:0] f);
        return {{(IMM_MAX_W-32){f[19]}}, f, 12'h000};
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy bits used for RAW stall detection.
//   clk, reset_n         clock, async active-low reset
//   flush                clears every busy bit on the next edge
//   set_en / set_addr    mark a destination busy (wins over a same-cycle clear)
//   clr_en / clr_addr    writeback retirement
//   qa_addr / qb_addr    two query ports; qX_busy excludes a register that is
//                        being retired this very cycle
// Register 0 is never busy.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] qa_addr,
    input  logic [AW-1:0] qb_addr,
    output logic          qa_busy,
    output logic          qb_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    // Next busy vector: set has priority over clear, bit 0 pinned low.
    always_comb begin
        w_busy_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_busy_next[i] = (set_en && (set_addr == AW'(i))) ||
                             (r_busy[i] && !(clr_en && (clr_addr == AW'(i))));
        end
    end

    // Busy bit storage; flush empties the scoreboard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // A register retiring this cycle is already free for a new reader.
    assign qa_busy = r_busy[qa_addr] && !(clr_en && (clr_addr == qa_addr));
    assign qb_busy = r_busy[qb_addr] && !(clr_en && (clr_addr == qb_addr));

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// RV64IM decode for OP-IMM, OP, OP-32, OP-IMM-32, LUI and AUIPC with a
// valid/ready handshake, one-cycle registered output, RAW scoreboard stall,
// flush and an illegal-instruction flag.
// Ports:
//   clk, reset_n                clock, async active-low reset
//   in_valid/in_ready           fetch handshake; in_ins, in_pc instruction + PC
//   flush                       drop the output bundle and clear the scoreboard
//   wb_valid/wb_rd              writeback retirement of a destination register
//   out_valid/out_ready         downstream handshake
//   alu_control, addressA/B/C, imm, muxB_control, rd_we, out_pc, out_illegal
//                               registered decoded bundle
// Build option: define DECODE_MEXT_EN to decode the M extension
// (funct7 = 0000001 on OP / OP-32); otherwise those encodings are illegal.
// Illegal encodings deliver a bundle with all fields zero except out_illegal
// and out_pc, and never stall on the scoreboard.
// LUI/AUIPC report addressA = 0 since they read no register.
// ---------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int ALU_CTRL_W     = 6,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_ins,
    input  logic [BUS_DATA_WIDTH-1:0] in_pc,
    input  logic                      flush,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALU_CTRL_W-1:0]     alu_control,
    output logic [4:0]                addressA,
    output logic [4:0]                addressB,
    output logic [4:0]                addressC,
    output logic [BUS_DATA_WIDTH-1:0] imm,
    output logic                      muxB_control,
    output logic                      rd_we,
    output logic [BUS_DATA_WIDTH-1:0] out_pc,
    output logic                      out_illegal
);

    localparam int AW       = $clog2(NUM_REGS);
    localparam bit IS_RV64  = (BUS_DATA_WIDTH == 64);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    decoded_t   w_dec;
    logic       w_qa_busy;
    logic       w_qb_busy;
    logic       w_hazard;
    logic       w_in_ready;
    logic       w_accept;

    logic                      r_out_valid;
    alu_op_e                   r_alu;
    logic [4:0]                r_addr_a;
    logic [4:0]                r_addr_b;
    logic [4:0]                r_addr_c;
    logic [BUS_DATA_WIDTH-1:0] r_imm;
    logic                      r_mux_b;
    logic                      r_rd_we;
    logic [BUS_DATA_WIDTH-1:0] r_pc;
    logic                      r_illegal;

    assign w_opc = in_ins[6:0];
    assign w_f3  = in_ins[14:12];
    assign w_f7  = in_ins[31:25];

    // Combinational instruction decode into the internal bundle.
    always_comb begin
        w_dec     = '0;
        w_dec.alu = ALU_NONE;
        w_dec.rd  = in_ins[11:7];
        case (w_opc)
            OPC_OP_IMM: begin
                w_dec.rs1     = in_ins[19:15];
                w_dec.use_rs1 = 1'b1;
                w_dec.mux_b   = 1'b1;
                w_dec.imm     = sext_i(in_ins[31:20]);
                case (w_f3)
                    3'b000: w_dec.alu = ALU_ADDI;
                    3'b010: w_dec.alu = ALU_SLTI;
                    3'b011: w_dec.alu = ALU_SLTIU;
                    3'b100: w_dec.alu = ALU_XORI;
                    3'b110: w_dec.alu = ALU_ORI;
                    3'b111: w_dec.alu = ALU_ANDI;
                    3'b001: begin
                        // shamt[5] only exists on RV64
                        w_dec.imm = {58'd0, in_ins[25:20]};
                        if ((in_ins[31:26] == 6'b000000) && (IS_RV64 || !in_ins[25])) begin
                            w_dec.alu = ALU_SLLI;
                        end else begin
                            w_dec.alu = ALU_NONE;
                        end
                    end
                    3'b101: begin
                        w_dec.imm = {58'd0, in_ins[25:20]};
                        if (!IS_RV64 && in_ins[25]) begin
                            w_dec.alu = ALU_NONE;
                        end else if (in_ins[31:26] == 6'b000000) begin
                            w_dec.alu = ALU_SRLI;
                        end else if (in_ins[31:26] == 6'b010000) begin
                            w_dec.alu = ALU_SRAI;
                        end else begin
                            w_dec.alu = ALU_NONE;
                        end
                    end
                    default: w_dec.alu = ALU_NONE;
                endcase
            end
            OPC_OP: begin
                w_dec.rs1     = in_ins[19:15];
                w_dec.rs2     = in_ins[24:20];
                w_dec.use_rs1 = 1'b1;
                w_dec.use_rs2 = 1'b1;
                case ({w_f7, w_f3})
                    {F7_BASE, 3'b000}: w_dec.alu = ALU_ADD;
                    {F7_ALT,  3'b000}: w_dec.alu = ALU_SUB;
                    {F7_BASE, 3'b001}: w_dec.alu = ALU_SLL;
                    {F7_BASE, 3'b010}: w_dec.alu = ALU_SLT;
                    {F7_BASE, 3'b011}: w_dec.alu = ALU_SLTU;
                    {F7_BASE, 3'b100}: w_dec.alu = ALU_XOR;
                    {F7_BASE, 3'b101}: w_dec.alu = ALU_SRL;
                    {F7_ALT,  3'b101}: w_dec.alu = ALU_SRA;
                    {F7_BASE, 3'b110}: w_dec.alu = ALU_OR;
                    {F7_BASE, 3'b111}: w_dec.alu = ALU_AND;
`ifdef DECODE_MEXT_EN
                    {F7_MEXT, 3'b000}: w_dec.alu = ALU_MUL;
                    {F7_MEXT, 3'b001}: w_dec.alu = ALU_MULH;
                    {F7_MEXT, 3'b010}: w_dec.alu = ALU_MULHSU;
                    {F7_MEXT, 3'b011}: w_dec.alu = ALU_MULHU;
                    {F7_MEXT, 3'b100}: w_dec.alu = ALU_DIV;
                    {F7_MEXT, 3'b101}: w_dec.alu = ALU_DIVU;
                    {F7_MEXT, 3'b110}: w_dec.alu = ALU_REM;
                    {F7_MEXT, 3'b111}: w_dec.alu = ALU_REMU;
`endif
                    default: w_dec.alu = ALU_NONE;
                endcase
            end
            OPC_OP_IMM_32: begin
                w_dec.rs1     = in_ins[19:15];
                w_dec.use_rs1 = 1'b1;
                w_dec.mux_b   = 1'b1;
                w_dec.imm     = sext_i(in_ins[31:20]);
                if (!IS_RV64) begin
                    w_dec.alu = ALU_NONE;
                end else begin
                    case ({w_f7, w_f3})
                        {F7_BASE, 3'b001}: w_dec.alu = ALU_SLLIW;
                        {F7_BASE, 3'b101}: w_dec.alu = ALU_SRLIW;
                        {F7_ALT,  3'b101}: w_dec.alu = ALU_SRAIW;
                        default: begin
                            // addiw has a free 12-bit immediate
                            if (w_f3 == 3'b000) begin
                                w_dec.alu = ALU_ADDIW;
                            end else begin
                                w_dec.alu = ALU_NONE;
                            end
                        end
                    endcase
                    // W shifts carry a 5-bit shamt; ins[25]=1 already fails funct7
                    if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                        w_dec.imm = {59'd0, in_ins[24:20]};
                    end else begin
                        w_dec.imm = sext_i(in_ins[31:20]);
                    end
                end
            end
            OPC_OP_32: begin
                w_dec.rs1     = in_ins[19:15];
                w_dec.rs2     = in_ins[24:20];
                w_dec.use_rs1 = 1'b1;
                w_dec.use_rs2 = 1'b1;
                if (!IS_RV64) begin
                    w_dec.alu = ALU_NONE;
                end else begin
                    case ({w_f7, w_f3})
                        {F7_BASE, 3'b000}: w_dec.alu = ALU_ADDW;
                        {F7_ALT,  3'b000}: w_dec.alu = ALU_SUBW;
                        {F7_BASE, 3'b001}: w_dec.alu = ALU_SLLW;
                        {F7_BASE, 3'b101}: w_dec.alu = ALU_SRLW;
                        {F7_ALT,  3'b101}: w_dec.alu = ALU_SRAW;
`ifdef DECODE_MEXT_EN
                        {F7_MEXT, 3'b000}: w_dec.alu = ALU_MULW;
                        {F7_MEXT, 3'b100}: w_dec.alu = ALU_DIVW;
                        {F7_MEXT, 3'b101}: w_dec.alu = ALU_DIVUW;
                        {F7_MEXT, 3'b110}: w_dec.alu = ALU_REMW;
                        {F7_MEXT, 3'b111}: w_dec.alu = ALU_REMUW;
`endif
                        default: w_dec.alu = ALU_NONE;
                    endcase
                end
            end
            OPC_LUI: begin
                w_dec.alu   = ALU_LUI;
                w_dec.mux_b = 1'b1;
                w_dec.imm   = sext_u(in_ins[31:12]);
            end
            OPC_AUIPC: begin
                w_dec.alu   = ALU_AUIPC;
                w_dec.mux_b = 1'b1;
                w_dec.imm   = sext_u(in_ins[31:12]);
            end
            default: w_dec.alu = ALU_NONE;
        endcase

        // Illegal encodings collapse to an all-zero bundle with the flag set.
        if (w_dec.alu == ALU_NONE) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end else begin
            w_dec.rd_we = (w_dec.rd != 5'd0);
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .set_en   (w_accept && w_dec.rd_we),
        .set_addr (w_dec.rd[AW-1:0]),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd[AW-1:0]),
        .qa_addr  (w_dec.rs1[AW-1:0]),
        .qb_addr  (w_dec.rs2[AW-1:0]),
        .qa_busy  (w_qa_busy),
        .qb_busy  (w_qb_busy)
    );

    assign w_hazard   = (w_dec.use_rs1 && w_qa_busy) || (w_dec.use_rs2 && w_qb_busy);
    assign w_in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // Output bundle register: load on accept, hold under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_alu       <= ALU_NONE;
            r_addr_a    <= 5'd0;
            r_addr_b    <= 5'd0;
            r_addr_c    <= 5'd0;
            r_imm       <= '0;
            r_mux_b     <= 1'b0;
            r_rd_we     <= 1'b0;
            r_pc        <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu       <= w_dec.alu;
            r_addr_a    <= w_dec.rs1;
            r_addr_b    <= w_dec.rs2;
            r_addr_c    <= w_dec.rd;
            r_imm       <= w_dec.imm[BUS_DATA_WIDTH-1:0];
            r_mux_b     <= w_dec.mux_b;
            r_rd_we     <= w_dec.rd_we;
            r_pc        <= in_pc;
            r_illegal   <= w_dec.illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign alu_control  = ALU_CTRL_W'(r_alu);
    assign addressA     = r_addr_a;
    assign addressB     = r_addr_b;
    assign addressC     = r_addr_c;
    assign imm          = r_imm;
    assign muxB_control = r_mux_b;
    assign rd_we        = r_rd_we;
    assign out_pc       = r_pc;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Directed scenarios followed by randomized traffic. Expected decode comes
// from a MATCH/MASK instruction table; the handshake and busy set are
// tracked as a plain bit vector and a valid flag.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam int F_I = 0, F_SH = 1, F_SHW = 2, F_R = 3, F_U = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] in_ins;
    logic [63:0] in_pc;
    logic        flush, wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid, out_ready;
    logic [5:0]  alu_control;
    logic [4:0]  addressA, addressB, addressC;
    logic [63:0] imm;
    logic        muxB_control, rd_we;
    logic [63:0] out_pc;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_stage #(.BUS_DATA_WIDTH(64), .ALU_CTRL_W(6), .NUM_REGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .addressA(addressA), .addressB(addressB),
        .addressC(addressC), .imm(imm), .muxB_control(muxB_control),
        .rd_we(rd_we), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] match;
        logic [31:0] mask;
        logic [5:0]  alu;
        int          fmt;
    } rule_t;

    typedef struct {
        logic [5:0]  alu;
        logic [4:0]  a, b, c;
        logic [63:0] imm;
        logic        mux, we, ill, u1, u2;
    } exp_t;

    rule_t       rules[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_valid;
    exp_t        m_out;
    logic [63:0] m_pc;
    bit   [31:0] m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add_rule(input logic [31:0] match, input logic [31:0] mask,
                            input logic [5:0] alu, input int fmt);
        rule_t r;
        r.match = match; r.mask = mask; r.alu = alu; r.fmt = fmt;
        rules.push_back(r);
    endtask

    task automatic build_rules();
        add_rule(32'h00000013, 32'h0000707f, 6'h01, F_I);
        add_rule(32'h00002013, 32'h0000707f, 6'h02, F_I);
        add_rule(32'h00003013, 32'h0000707f, 6'h03, F_I);
        add_rule(32'h00004013, 32'h0000707f, 6'h04, F_I);
        add_rule(32'h00006013, 32'h0000707f, 6'h05, F_I);
        add_rule(32'h00007013, 32'h0000707f, 6'h06, F_I);
        add_rule(32'h00001013, 32'hfc00707f, 6'h07, F_SH);
        add_rule(32'h00005013, 32'hfc00707f, 6'h08, F_SH);
        add_rule(32'h40005013, 32'hfc00707f, 6'h09, F_SH);
        add_rule(32'h00000033, 32'hfe00707f, 6'h0C, F_R);
        add_rule(32'h40000033, 32'hfe00707f, 6'h0D, F_R);
        add_rule(32'h00001033, 32'hfe00707f, 6'h0E, F_R);
        add_rule(32'h00002033, 32'hfe00707f, 6'h0F, F_R);
        add_rule(32'h00003033, 32'hfe00707f, 6'h10, F_R);
        add_rule(32'h00004033, 32'hfe00707f, 6'h11, F_R);
        add_rule(32'h00005033, 32'hfe00707f, 6'h12, F_R);
        add_rule(32'h40005033, 32'hfe00707f, 6'h13, F_R);
        add_rule(32'h00006033, 32'hfe00707f, 6'h14, F_R);
        add_rule(32'h00007033, 32'hfe00707f, 6'h15, F_R);
        add_rule(32'h0000001b, 32'h0000707f, 6'h16, F_I);
        add_rule(32'h0000101b, 32'hfe00707f, 6'h17, F_SHW);
        add_rule(32'h0000501b, 32'hfe00707f, 6'h18, F_SHW);
        add_rule(32'h4000501b, 32'hfe00707f, 6'h19, F_SHW);
        add_rule(32'h0000003b, 32'hfe00707f, 6'h1A, F_R);
        add_rule(32'h4000003b, 32'hfe00707f, 6'h1B, F_R);
        add_rule(32'h0000103b, 32'hfe00707f, 6'h1C, F_R);
        add_rule(32'h0000503b, 32'hfe00707f, 6'h1D, F_R);
        add_rule(32'h4000503b, 32'hfe00707f, 6'h1E, F_R);
`ifdef DECODE_MEXT_EN
        add_rule(32'h02000033, 32'hfe00707f, 6'h1F, F_R);
        add_rule(32'h02001033, 32'hfe00707f, 6'h20, F_R);
        add_rule(32'h02002033, 32'hfe00707f, 6'h21, F_R);
        add_rule(32'h02003033, 32'hfe00707f, 6'h22, F_R);
        add_rule(32'h02004033, 32'hfe00707f, 6'h23, F_R);
        add_rule(32'h02005033, 32'hfe00707f, 6'h24, F_R);
        add_rule(32'h02006033, 32'hfe00707f, 6'h25, F_R);
        add_rule(32'h02007033, 32'hfe00707f, 6'h26, F_R);
        add_rule(32'h0200003b, 32'hfe00707f, 6'h27, F_R);
        add_rule(32'h0200403b, 32'hfe00707f, 6'h28, F_R);
        add_rule(32'h0200503b, 32'hfe00707f, 6'h29, F_R);
        add_rule(32'h0200603b, 32'hfe00707f, 6'h2A, F_R);
        add_rule(32'h0200703b, 32'hfe00707f, 6'h2B, F_R);
`endif
        add_rule(32'h00000037, 32'h0000007f, 6'h2C, F_U);
        add_rule(32'h00000017, 32'h0000007f, 6'h2D, F_U);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t   e;
        longint s;
        e = '{alu: 6'h00, a: 5'd0, b: 5'd0, c: 5'd0, imm: 64'd0,
              mux: 1'b0, we: 1'b0, ill: 1'b1, u1: 1'b0, u2: 1'b0};
        foreach (rules[k]) begin
            if ((ins & rules[k].mask) == rules[k].match) begin
                e.ill = 1'b0;
                e.alu = rules[k].alu;
                e.c   = ins[11:7];
                e.we  = (ins[11:7] != 5'd0);
                case (rules[k].fmt)
                    F_I: begin
                        e.a = ins[19:15]; e.u1 = 1'b1; e.mux = 1'b1;
                        s = $signed(ins[31:20]);
                        e.imm = s;
                    end
                    F_SH: begin
                        e.a = ins[19:15]; e.u1 = 1'b1; e.mux = 1'b1;
                        e.imm = 64'(ins[25:20]);
                    end
                    F_SHW: begin
                        e.a = ins[19:15]; e.u1 = 1'b1; e.mux = 1'b1;
                        e.imm = 64'(ins[24:20]);
                    end
                    F_R: begin
                        e.a = ins[19:15]; e.b = ins[24:20];
                        e.u1 = 1'b1; e.u2 = 1'b1;
                    end
                    default: begin
                        e.mux = 1'b1;
                        s = $signed({ins[31:12], 12'h000});
                        e.imm = s;
                    end
                endcase
            end
        end
        return e;
    endfunction

    function automatic bit busy_now(input logic [4:0] r, input bit wbv, input logic [4:0] wbrd);
        return (r != 5'd0) && m_busy[r] && !(wbv && (wbrd == r));
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int          k;
        if ($urandom_range(0, 9) == 0) begin
            w = $urandom;
        end else begin
            k = $urandom_range(0, rules.size() - 1);
            w = rules[k].match | ($urandom & ~rules[k].mask);
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    task automatic compare_outputs(input string where);
        check({where, "/out_valid"}, 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check({where, "/alu"},     64'(alu_control),  64'(m_out.alu));
            check({where, "/addrA"},   64'(addressA),     64'(m_out.a));
            check({where, "/addrB"},   64'(addressB),     64'(m_out.b));
            check({where, "/addrC"},   64'(addressC),     64'(m_out.c));
            check({where, "/imm"},     imm,               m_out.imm);
            check({where, "/muxB"},    64'(muxB_control), 64'(m_out.mux));
            check({where, "/rd_we"},   64'(rd_we),        64'(m_out.we));
            check({where, "/illegal"}, 64'(out_illegal),  64'(m_out.ill));
            check({where, "/pc"},      out_pc,            m_pc);
        end
        check({where, "/busy"}, 64'(dut.u_scoreboard.r_busy), 64'(m_busy));
    endtask

    // One cycle: drive at negedge, check ready, advance model, check after edge.
    task automatic step(input string where, input bit v, input logic [31:0] ins,
                        input logic [63:0] pc, input bit ordy, input bit fl,
                        input bit wbv, input logic [4:0] wbrd);
        exp_t e;
        bit   rdy;
        @(negedge clk);
        in_valid = v; in_ins = ins; in_pc = pc; out_ready = ordy;
        flush = fl; wb_valid = wbv; wb_rd = wbrd;
        #1;
        e   = ref_decode(ins);
        rdy = !fl && !((e.u1 && busy_now(e.a, wbv, wbrd)) || (e.u2 && busy_now(e.b, wbv, wbrd)))
              && (!m_valid || ordy);
        check({where, "/in_ready"}, 64'(in_ready), 64'(rdy));
        if (fl) begin
            m_valid = 1'b0;
            m_busy  = '0;
        end else begin
            if (wbv) m_busy[wbrd] = 1'b0;
            if (v && rdy) begin
                m_valid = 1'b1;
                m_out   = e;
                m_pc    = pc;
                if (e.we) m_busy[e.c] = 1'b1;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        compare_outputs(where);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_busy  = '0;
        m_out   = ref_decode(32'h0);
        m_pc    = 64'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        build_rules();
        model_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_ins = 32'h0; in_pc = 64'h0;
        out_ready = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
        #12;
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/alu",       64'(alu_control), 64'd0);
        check("reset/imm",       imm, 64'd0);
        check("reset/busy",      64'(dut.u_scoreboard.r_busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // addi x1,x2,-1
        step("t1", 1'b1, 32'hFFF10093, 64'h1000, 1'b1, 1'b0, 1'b0, 5'd0);
        check("t1/alu_const", 64'(alu_control), 64'h01);
        check("t1/imm_const", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1/busy1",     64'(dut.u_scoreboard.r_busy[1]), 64'd1);

        // srai x3,x4,63
        step("t2", 1'b1, 32'h43F25193, 64'h1004, 1'b1, 1'b0, 1'b0, 5'd0);
        check("t2/alu_const", 64'(alu_control), 64'h09);
        check("t2/imm_const", imm, 64'd63);

        // mul x5,x6,x7
        step("t3", 1'b1, 32'h027302B3, 64'h1008, 1'b1, 1'b0, 1'b0, 5'd0);
`ifdef DECODE_MEXT_EN
        check("t3/alu_const", 64'(alu_control), 64'h1F);
        check("t3/addrB",     64'(addressB), 64'd7);
`else
        check("t3/illegal",   64'(out_illegal), 64'd1);
        check("t3/alu_const", 64'(alu_control), 64'h00);
        check("t3/busy5",     64'(dut.u_scoreboard.r_busy[5]), 64'd0);
`endif

        // add x8,x1,x1 stalls until x1 retires, accepted in the retire cycle
        for (int i = 0; i < 3; i++)
            step("t4_stall", 1'b1, 32'h00108433, 64'h100C, 1'b1, 1'b0, 1'b0, 5'd0);
        check("t4/stalled", 64'(in_ready), 64'd0);
        step("t4_wb", 1'b1, 32'h00108433, 64'h100C, 1'b1, 1'b0, 1'b1, 5'd1);
        check("t4/busy8", 64'(dut.u_scoreboard.r_busy[8]), 64'd1);
        check("t4/alu",   64'(alu_control), 64'h0C);

        // backpressure then flush; addi x9,x0,1
        step("t5_load", 1'b1, 32'h00100493, 64'h2000, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++)
            step("t5_hold", 1'b1, 32'h00000013, 64'h2004, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t5_flush", 1'b1, 32'h00000013, 64'h2004, 1'b0, 1'b1, 1'b0, 5'd0);
        check("t5/valid", 64'(out_valid), 64'd0);
        check("t5/busy",  64'(dut.u_scoreboard.r_busy), 64'd0);

        // asynchronous reset in the middle of a stall
        step("t6_load", 1'b1, 32'h00100493, 64'h3000, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t6_hold", 1'b1, 32'h00208513, 64'h3004, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("t6/valid", 64'(out_valid), 64'd0);
        check("t6/alu",   64'(alu_control), 64'd0);
        check("t6/addrC", 64'(addressC), 64'd0);
        check("t6/imm",   imm, 64'd0);
        check("t6/rd_we", 64'(rd_we), 64'd0);
        check("t6/busy",  64'(dut.u_scoreboard.r_busy), 64'd0);
        in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] wr;
            wr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step("rand", ($urandom_range(0, 4) != 0), rand_ins(), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) == 0), wr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
